aurora_20g_adc_gen: RTL and testbench

- Test-pattern source for the 20G Aurora ADC path. It is the transmit-side counterpart of the ADC pattern checker.
- Produces 128-bit beats of eight 16-bit ramp samples with a valid/ready handshake.
- Supports configurable burst and gap lengths, so the link and the downstream checker can be soaked without real ADC data.
- Sits in front of the Aurora TX user interface, in place of the ADC capture mux.

---
 rtl/aurora_adc_gen_pkg.sv | 24 ++
 rtl/aurora_adc_pat_gen.sv | 40 ++++
 rtl/aurora_20g_adc_gen.sv | 193 +++++++++++++++++++
 tb/tb_aurora_20g_adc_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/aurora_adc_gen_pkg.sv
// Shared constants and beat formation for the Aurora ADC ramp-pattern generator.
package aurora_adc_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam int LANE_NUM       = 8;
   localparam int LANE_WD        = 16;
   localparam int BEATS_PER_BASE = 4;
   localparam int BASE_STEP      = 4;
   localparam int BEAT_WD        = LANE_NUM * LANE_WD;

   // Lane i carries base + (i mod 4), each lane wrapping on its own.
   function automatic logic [BEAT_WD-1:0] form_beat(input logic [LANE_WD-1:0] base);
      logic [BEAT_WD-1:0] r;
      r = '0;
      for (int i = 0; i < LANE_NUM; i++) begin
         r[i*LANE_WD +: LANE_WD] = base + LANE_WD'(i % BEATS_PER_BASE);
      end
      return r;
   endfunction

endpackage

// File: rtl/aurora_adc_pat_gen.sv
// Ramp pattern state (base/beat); next_data is the beat that is current after this cycle's advance.
module aurora_adc_pat_gen
   import aurora_adc_gen_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               advance,
   output logic [BEAT_WD-1:0] next_data
);

   logic [LANE_WD-1:0] base_q, base_d;
   logic [1:0]         beat_q, beat_d;

   always_comb begin
      base_d = base_q;
      beat_d = beat_q;
      if (clear) begin
         base_d = '0;
         beat_d = '0;
      end else if (advance) begin
         beat_d = beat_q + 2'd1;
         if (beat_q == 2'(BEATS_PER_BASE - 1)) begin
            base_d = base_q + LANE_WD'(BASE_STEP);
         end
      end
      next_data = form_beat(base_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q <= '0;
         beat_q <= '0;
      end else begin
         base_q <= base_d;
         beat_q <= beat_d;
      end
   end

endmodule

// File: rtl/aurora_20g_adc_gen.sv
// Burst/gap ramp-pattern source for the 20G Aurora ADC path, valid/ready output, registered beat.
// Optional single-beat bit-0 corruption is built only with AURORA_ADC_GEN_ERR_INJ_EN defined.
module aurora_20g_adc_gen
   import aurora_adc_gen_pkg::*;
#(
   parameter int DATA_WD = 128,
   parameter int LEN_WD  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_rst,
   input  logic               cfg_en,
   input  logic [LEN_WD-1:0]  cfg_burst_len,
   input  logic [LEN_WD-1:0]  cfg_gap_len,
   input  logic               cfg_err_inj,
   input  logic               adc_rdy,
   output logic               adc_vld,
   output logic [DATA_WD-1:0] adc_data,
   output logic [31:0]        tx_cnt,
   output logic [31:0]        inj_cnt,
   output logic               busy
);

   logic [1:0]         state_q, state_d;
   logic               vld_q, vld_d;
   logic [DATA_WD-1:0] data_q, data_d;
   logic [LEN_WD-1:0]  burst_cnt_q, burst_cnt_d;
   logic [LEN_WD-1:0]  gap_cnt_q, gap_cnt_d;
   logic [LEN_WD-1:0]  gap_len_q, gap_len_d;
   logic               cont_q, cont_d;
   logic [31:0]        tx_cnt_q, tx_cnt_d;

   logic               xfer;
   logic               load;
   logic               start;
   logic [DATA_WD-1:0] next_data;
   logic [DATA_WD-1:0] inj_mask;

   assign xfer = vld_q && adc_rdy;

   aurora_adc_pat_gen u_pat (
      .clk       (clk),
      .rst       (rst),
      .clear     (cfg_rst),
      .advance   (xfer),
      .next_data (next_data)
   );

   always_comb begin
      state_d     = state_q;
      vld_d       = vld_q;
      data_d      = data_q;
      burst_cnt_d = burst_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      gap_len_d   = gap_len_q;
      cont_d      = cont_q;
      tx_cnt_d    = tx_cnt_q + 32'(xfer);
      load        = 1'b0;
      start       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_en) start = 1'b1;
         end
         ST_RUN: begin
            if (xfer) begin
               // Disable wins over end-of-burst so a falling cfg_en never lands in GAP.
               if (!cfg_en) begin
                  state_d = ST_IDLE;
                  vld_d   = 1'b0;
               end else if (!cont_q && burst_cnt_q == LEN_WD'(1)) begin
                  if (gap_len_q != '0) begin
                     state_d   = ST_GAP;
                     vld_d     = 1'b0;
                     gap_cnt_d = gap_len_q;
                  end else begin
                     start = 1'b1;
                  end
               end else begin
                  burst_cnt_d = burst_cnt_q - LEN_WD'(1);
                  load        = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q <= LEN_WD'(1)) begin
               if (cfg_en) start = 1'b1;
               else        state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - LEN_WD'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Burst configuration is captured only here, at the start of each burst.
      if (start) begin
         state_d     = ST_RUN;
         burst_cnt_d = cfg_burst_len;
         cont_d      = (cfg_burst_len == '0);
         gap_len_d   = cfg_gap_len;
         load        = 1'b1;
      end

      if (load) begin
         vld_d  = 1'b1;
         data_d = next_data ^ inj_mask;
      end

      if (cfg_rst) begin
         state_d     = ST_IDLE;
         vld_d       = 1'b0;
         data_d      = '0;
         burst_cnt_d = '0;
         gap_cnt_d   = '0;
         gap_len_d   = '0;
         cont_d      = 1'b0;
         tx_cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         vld_q       <= 1'b0;
         data_q      <= '0;
         burst_cnt_q <= '0;
         gap_cnt_q   <= '0;
         gap_len_q   <= '0;
         cont_q      <= 1'b0;
         tx_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         vld_q       <= vld_d;
         data_q      <= data_d;
         burst_cnt_q <= burst_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         gap_len_q   <= gap_len_d;
         cont_q      <= cont_d;
         tx_cnt_q    <= tx_cnt_d;
      end
   end

`ifdef AURORA_ADC_GEN_ERR_INJ_EN
   logic        arm_q, arm_d;
   logic        inj_cur_q, inj_cur_d;
   logic        inj_new;
   logic [31:0] inj_cnt_q, inj_cnt_d;

   // inj_cur_q marks the beat on the output as the corrupted one; arm holds until it transfers.
   always_comb begin
      inj_new   = (arm_q || cfg_err_inj) && !inj_cur_q;
      inj_mask  = {{(DATA_WD-1){1'b0}}, inj_new};
      arm_d     = arm_q;
      inj_cur_d = inj_cur_q;
      inj_cnt_d = inj_cnt_q + 32'(xfer && inj_cur_q);
      if (xfer && inj_cur_q) arm_d = 1'b0;
      if (cfg_err_inj && !arm_q) arm_d = 1'b1;
      if (load)      inj_cur_d = inj_new;
      else if (xfer) inj_cur_d = 1'b0;
      if (cfg_rst) begin
         arm_d     = 1'b0;
         inj_cur_d = 1'b0;
         inj_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm_q     <= 1'b0;
         inj_cur_q <= 1'b0;
         inj_cnt_q <= '0;
      end else begin
         arm_q     <= arm_d;
         inj_cur_q <= inj_cur_d;
         inj_cnt_q <= inj_cnt_d;
      end
   end

   assign inj_cnt = inj_cnt_q;
`else
   logic unused_err_inj;
   assign unused_err_inj = cfg_err_inj;
   assign inj_mask       = '0;
   assign inj_cnt        = '0;
`endif

   assign adc_vld  = vld_q;
   assign adc_data = data_q;
   assign tx_cnt   = tx_cnt_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aurora_20g_adc_gen.sv
// Directed bench for aurora_20g_adc_gen: continuous, burst/gap, backpressure, disable, cfg_rst, injection, wrap.
module tb_aurora_20g_adc_gen;

   logic         clk = 1'b0;
   logic         rst;
   logic         cfg_rst;
   logic         cfg_en;
   logic [15:0]  cfg_burst_len;
   logic [15:0]  cfg_gap_len;
   logic         cfg_err_inj;
   logic         adc_rdy;
   logic         adc_vld;
   logic [127:0] adc_data;
   logic [31:0]  tx_cnt;
   logic [31:0]  inj_cnt;
   logic         busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   aurora_20g_adc_gen dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_rst       (cfg_rst),
      .cfg_en        (cfg_en),
      .cfg_burst_len (cfg_burst_len),
      .cfg_gap_len   (cfg_gap_len),
      .cfg_err_inj   (cfg_err_inj),
      .adc_rdy       (adc_rdy),
      .adc_vld       (adc_vld),
      .adc_data      (adc_data),
      .tx_cnt        (tx_cnt),
      .inj_cnt       (inj_cnt),
      .busy          (busy)
   );

   function automatic logic [127:0] pat(input logic [15:0] b);
      logic [15:0] l0, l1, l2, l3;
      l0 = b;
      l1 = b + 16'd1;
      l2 = b + 16'd2;
      l3 = b + 16'd3;
      return {l3, l2, l1, l0, l3, l2, l1, l0};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pulse_cfg_rst();
      cfg_rst = 1'b1;
      @(negedge clk);
      cfg_rst = 1'b0;
   endtask

   localparam bit [10:0] BG_VLD = 11'b100_1110_0111;
   int bg_base [11] = '{0, 0, 0, 0, 0, 0, 4, 4, 0, 0, 4};
   int idx;

   initial begin
      rst           = 1'b1;
      cfg_rst       = 1'b0;
      cfg_en        = 1'b0;
      cfg_burst_len = 16'd0;
      cfg_gap_len   = 16'd0;
      cfg_err_inj   = 1'b0;
      adc_rdy       = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_vld",  128'(adc_vld), 128'(0));
      check("rst_data", adc_data,      128'(0));
      check("rst_tx",   128'(tx_cnt),  128'(0));
      check("rst_inj",  128'(inj_cnt), 128'(0));
      check("rst_busy", 128'(busy),    128'(0));

      // Continuous run, 12 beats, disabled while beat 11 is presented.
      cfg_en  = 1'b1;
      adc_rdy = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("cont_vld",  128'(adc_vld), 128'(1));
         check("cont_data", adc_data, pat(16'(4 * (k / 4))));
         if (k == 4) check("cont_b4_lit", adc_data, 128'h0007_0006_0005_0004_0007_0006_0005_0004);
         if (k == 11) cfg_en = 1'b0;
      end
      @(negedge clk);
      check("cont_idle_vld", 128'(adc_vld), 128'(0));
      check("cont_tx12",     128'(tx_cnt),  128'(12));
      check("cont_busy",     128'(busy),    128'(0));
      cfg_en = 1'b1;
      @(negedge clk);
      check("persist_base12", adc_data, pat(16'd12));
      cfg_en = 1'b0;
      @(negedge clk);
      pulse_cfg_rst();
      check("crst_tx",   128'(tx_cnt), 128'(0));
      check("crst_data", adc_data,     128'(0));

      // Burst 3, gap 2.
      cfg_burst_len = 16'd3;
      cfg_gap_len   = 16'd2;
      cfg_en        = 1'b1;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         check("bg_vld",  128'(adc_vld), 128'(BG_VLD[c]));
         check("bg_busy", 128'(busy),    128'(1));
         if (BG_VLD[c]) check("bg_data", adc_data, pat(16'(bg_base[c])));
         if (c == 10) begin
            check("bg_tx6", 128'(tx_cnt), 128'(6));
            cfg_en = 1'b0;
         end
      end
      @(negedge clk);
      check("bg_off_vld", 128'(adc_vld), 128'(0));
      check("bg_off_tx",  128'(tx_cnt),  128'(7));

      // Backpressure: ready toggles, stalled beats hold, 8 transfers.
      pulse_cfg_rst();
      cfg_burst_len = 16'd0;
      cfg_gap_len   = 16'd0;
      cfg_en        = 1'b1;
      adc_rdy       = 1'b0;
      idx           = 0;
      for (int c = 0; c <= 16; c++) begin
         @(negedge clk);
         check("bp_vld",  128'(adc_vld), 128'(1));
         check("bp_data", adc_data, pat(16'(4 * (idx / 4))));
         if (c < 16) begin
            adc_rdy = (c % 2 == 1);
            if (adc_rdy) idx++;
         end
      end
      check("bp_base8", adc_data, pat(16'd8));

      // Disable while stalled: beat must be held until taken.
      adc_rdy = 1'b0;
      cfg_en  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_vld",  128'(adc_vld), 128'(1));
         check("stall_data", adc_data, pat(16'd8));
      end
      adc_rdy = 1'b1;
      @(negedge clk);
      check("stall_idle_vld",  128'(adc_vld), 128'(0));
      check("stall_idle_busy", 128'(busy),    128'(0));
      check("stall_tx9",       128'(tx_cnt),  128'(9));

      // cfg_rst in the middle of a run.
      cfg_en = 1'b1;
      repeat (5) @(negedge clk);
      cfg_rst = 1'b1;
      @(negedge clk);
      check("mrst_vld",  128'(adc_vld), 128'(0));
      check("mrst_tx",   128'(tx_cnt),  128'(0));
      check("mrst_busy", 128'(busy),    128'(0));
      cfg_rst = 1'b0;
      @(negedge clk);
      check("mrst_restart_vld",  128'(adc_vld), 128'(1));
      check("mrst_restart_data", adc_data, pat(16'd0));

      // Error injection pulsed while beat 5 is presented.
      pulse_cfg_rst();
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
`ifdef AURORA_ADC_GEN_ERR_INJ_EN
         if (k == 6) check("inj_b6", adc_data, pat(16'd4) ^ 128'd1);
         else        check("inj_data", adc_data, pat(16'(4 * (k / 4))));
         if (k == 7) check("inj_cnt1", 128'(inj_cnt), 128'(1));
`else
         check("inj_data", adc_data, pat(16'(4 * (k / 4))));
         if (k == 7) check("inj_cnt0", 128'(inj_cnt), 128'(0));
`endif
         cfg_err_inj = (k == 5);
      end
      cfg_err_inj = 1'b0;

      // Base wrap after 65536 beats.
      pulse_cfg_rst();
      for (int k = 0; k <= 65536; k++) begin
         @(negedge clk);
         if (k == 65535) begin
            check("wrap_vld",  128'(adc_vld), 128'(1));
            check("wrap_last", adc_data, 128'hFFFF_FFFE_FFFD_FFFC_FFFF_FFFE_FFFD_FFFC);
         end
         if (k == 65536) begin
            check("wrap_zero", adc_data, pat(16'd0));
            check("wrap_tx",   128'(tx_cnt), 128'(65536));
         end
      end
      cfg_en = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
